// File: rtl/mem_axi_window_bridge.sv
// AXI4 bridge from the Rocket memory port to the Zynq HP slave port. It relocates the Rocket
// memory window into reserved DDR and answers out-of-window bursts locally with DECERR.
module mem_axi_window_bridge #(
  parameter logic [3:0]  WIN_TAG = 4'h8,
  parameter logic [3:0]  DDR_TAG = 4'h1,
  parameter int unsigned ID_W    = 6,
  parameter int unsigned MAX_OUT = 8
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            s_aw_valid,
  output logic            s_aw_ready,
  input  logic [31:0]     s_aw_addr,
  input  logic [ID_W-1:0] s_aw_id,
  input  logic [7:0]      s_aw_len,
  input  logic [2:0]      s_aw_size,
  input  logic [1:0]      s_aw_burst,
  input  logic            s_w_valid,
  output logic            s_w_ready,
  input  logic [63:0]     s_w_data,
  input  logic [7:0]      s_w_strb,
  input  logic            s_w_last,
  output logic            s_b_valid,
  input  logic            s_b_ready,
  output logic [ID_W-1:0] s_b_id,
  output logic [1:0]      s_b_resp,
  input  logic            s_ar_valid,
  output logic            s_ar_ready,
  input  logic [31:0]     s_ar_addr,
  input  logic [ID_W-1:0] s_ar_id,
  input  logic [7:0]      s_ar_len,
  input  logic [2:0]      s_ar_size,
  input  logic [1:0]      s_ar_burst,
  output logic            s_r_valid,
  input  logic            s_r_ready,
  output logic [ID_W-1:0] s_r_id,
  output logic [63:0]     s_r_data,
  output logic [1:0]      s_r_resp,
  output logic            s_r_last,
  output logic            m_aw_valid,
  input  logic            m_aw_ready,
  output logic [31:0]     m_aw_addr,
  output logic [ID_W-1:0] m_aw_id,
  output logic [7:0]      m_aw_len,
  output logic [2:0]      m_aw_size,
  output logic [1:0]      m_aw_burst,
  output logic [3:0]      m_aw_cache,
  output logic [2:0]      m_aw_prot,
  output logic [3:0]      m_aw_qos,
  output logic            m_aw_lock,
  output logic            m_w_valid,
  input  logic            m_w_ready,
  output logic [63:0]     m_w_data,
  output logic [7:0]      m_w_strb,
  output logic            m_w_last,
  input  logic            m_b_valid,
  output logic            m_b_ready,
  input  logic [ID_W-1:0] m_b_id,
  input  logic [1:0]      m_b_resp,
  output logic            m_ar_valid,
  input  logic            m_ar_ready,
  output logic [31:0]     m_ar_addr,
  output logic [ID_W-1:0] m_ar_id,
  output logic [7:0]      m_ar_len,
  output logic [2:0]      m_ar_size,
  output logic [1:0]      m_ar_burst,
  output logic [3:0]      m_ar_cache,
  output logic [2:0]      m_ar_prot,
  output logic [3:0]      m_ar_qos,
  output logic            m_ar_lock,
  input  logic            m_r_valid,
  output logic            m_r_ready,
  input  logic [ID_W-1:0] m_r_id,
  input  logic [63:0]     m_r_data,
  input  logic [1:0]      m_r_resp,
  input  logic            m_r_last
);
  localparam logic [3:0] MaxOut = 4'(MAX_OUT);

  typedef enum logic [1:0] {WrIdle, WrSink, WrResp} wr_state_e;
  typedef enum logic {RdIdle, RdErr} rd_state_e;

  wr_state_e       ws_q, ws_d;
  rd_state_e       rs_q, rs_d;
  logic            live_q;
  logic            aw_full_q, ar_full_q;
  logic [31:0]     aw_addr_q, ar_addr_q;
  logic [ID_W-1:0] aw_id_q, ar_id_q, err_wid_q, err_rid_q;
  logic [7:0]      aw_len_q, ar_len_q, err_rlen_q, rbeat_q, rbeat_d;
  logic [2:0]      aw_size_q, ar_size_q;
  logic [1:0]      aw_burst_q, ar_burst_q;
  logic [3:0]      wr_out_q, rd_out_q, w_pend_q;
  logic            aw_good, ar_good, aw_fwd, ar_fwd, aw_take_bad, ar_take_bad;
  logic            aw_acc, ar_acc, w_route;

  // Saturating up/down counter; simultaneous inc and dec cancel.
  function automatic logic [3:0] count_next(logic [3:0] cnt, logic inc, logic dec);
    logic [3:0] nxt;
    nxt = cnt;
    if (inc && !dec && cnt != MaxOut) nxt = cnt + 4'd1;
    else if (dec && !inc && cnt != 4'd0) nxt = cnt - 4'd1;
    return nxt;
  endfunction

  assign aw_good     = aw_addr_q[31:28] == WIN_TAG;
  assign ar_good     = ar_addr_q[31:28] == WIN_TAG;
  assign m_aw_valid  = live_q && aw_full_q && aw_good && wr_out_q != MaxOut;
  assign m_ar_valid  = live_q && ar_full_q && ar_good && rd_out_q != MaxOut;
  assign aw_fwd      = m_aw_valid && m_aw_ready;
  assign ar_fwd      = m_ar_valid && m_ar_ready;
  // Bad bursts are only answered once every forwarded burst in that direction has completed.
  assign aw_take_bad = live_q && aw_full_q && !aw_good && ws_q == WrIdle &&
                       wr_out_q == 4'd0 && w_pend_q == 4'd0;
  assign ar_take_bad = live_q && ar_full_q && !ar_good && rs_q == RdIdle && rd_out_q == 4'd0;
  assign s_aw_ready  = live_q && ws_q == WrIdle && (!aw_full_q || aw_fwd) &&
                       !(s_aw_addr[31:28] == WIN_TAG && wr_out_q == MaxOut);
  assign s_ar_ready  = live_q && (!ar_full_q || ar_fwd) &&
                       !(s_ar_addr[31:28] == WIN_TAG && rd_out_q == MaxOut);
  assign aw_acc      = s_aw_valid && s_aw_ready;
  assign ar_acc      = s_ar_valid && s_ar_ready;
  assign w_route     = ws_q != WrSink && (w_pend_q != 4'd0 || (aw_full_q && aw_good));

  assign m_aw_addr  = {DDR_TAG, aw_addr_q[27:0]};
  assign m_aw_id    = aw_id_q;
  assign m_aw_len   = aw_len_q;
  assign m_aw_size  = aw_size_q;
  assign m_aw_burst = aw_burst_q;
  assign m_aw_cache = 4'b0011;
  assign m_aw_prot  = 3'b000;
  assign m_aw_qos   = 4'b0000;
  assign m_aw_lock  = 1'b0;
  assign m_ar_addr  = {DDR_TAG, ar_addr_q[27:0]};
  assign m_ar_id    = ar_id_q;
  assign m_ar_len   = ar_len_q;
  assign m_ar_size  = ar_size_q;
  assign m_ar_burst = ar_burst_q;
  assign m_ar_cache = 4'b0011;
  assign m_ar_prot  = 3'b000;
  assign m_ar_qos   = 4'b0000;
  assign m_ar_lock  = 1'b0;
  assign m_w_data   = s_w_data;
  assign m_w_strb   = s_w_strb;
  assign m_w_last   = s_w_last;

  always_comb begin
    ws_d      = ws_q;
    m_w_valid = live_q && s_w_valid && w_route;
    s_w_ready = live_q && m_w_ready && w_route;
    s_b_valid = live_q && m_b_valid;
    s_b_id    = m_b_id;
    s_b_resp  = m_b_resp;
    m_b_ready = live_q && s_b_ready;
    unique case (ws_q)
      WrIdle: if (aw_take_bad) ws_d = WrSink;
      WrSink: begin
        m_w_valid = 1'b0;
        s_w_ready = 1'b1;
        if (s_w_valid && s_w_last) ws_d = WrResp;
      end
      WrResp: begin
        s_b_valid = 1'b1;
        s_b_id    = err_wid_q;
        s_b_resp  = 2'b11;
        m_b_ready = 1'b0;
        if (s_b_ready) ws_d = WrIdle;
      end
      default: ws_d = WrIdle;
    endcase
  end

  always_comb begin
    rs_d      = rs_q;
    rbeat_d   = rbeat_q;
    s_r_valid = live_q && m_r_valid;
    s_r_id    = m_r_id;
    s_r_data  = m_r_data;
    s_r_resp  = m_r_resp;
    s_r_last  = m_r_last;
    m_r_ready = live_q && s_r_ready;
    unique case (rs_q)
      RdIdle: if (ar_take_bad) begin
        rs_d    = RdErr;
        rbeat_d = 8'd0;
      end
      RdErr: begin
        s_r_valid = 1'b1;
        s_r_id    = err_rid_q;
        s_r_data  = 64'd0;
        s_r_resp  = 2'b11;
        s_r_last  = rbeat_q == err_rlen_q;
        m_r_ready = 1'b0;
        if (s_r_ready) begin
          if (rbeat_q == err_rlen_q) rs_d = RdIdle;
          else rbeat_d = rbeat_q + 8'd1;
        end
      end
      default: rs_d = RdIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      live_q     <= 1'b0;
      ws_q       <= WrIdle;
      rs_q       <= RdIdle;
      aw_full_q  <= 1'b0;
      ar_full_q  <= 1'b0;
      aw_addr_q  <= '0;
      aw_id_q    <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      ar_addr_q  <= '0;
      ar_id_q    <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      wr_out_q   <= '0;
      rd_out_q   <= '0;
      w_pend_q   <= '0;
      err_wid_q  <= '0;
      err_rid_q  <= '0;
      err_rlen_q <= '0;
      rbeat_q    <= '0;
    end else begin
      live_q   <= 1'b1;
      ws_q     <= ws_d;
      rs_q     <= rs_d;
      rbeat_q  <= rbeat_d;
      wr_out_q <= count_next(wr_out_q, aw_fwd, m_b_valid && m_b_ready);
      rd_out_q <= count_next(rd_out_q, ar_fwd, m_r_valid && m_r_ready && m_r_last);
      w_pend_q <= count_next(w_pend_q, aw_fwd, m_w_valid && m_w_ready && s_w_last);
      if (aw_acc) begin
        aw_full_q  <= 1'b1;
        aw_addr_q  <= s_aw_addr;
        aw_id_q    <= s_aw_id;
        aw_len_q   <= s_aw_len;
        aw_size_q  <= s_aw_size;
        aw_burst_q <= s_aw_burst;
      end else if (aw_fwd || aw_take_bad) begin
        aw_full_q <= 1'b0;
      end
      if (ar_acc) begin
        ar_full_q  <= 1'b1;
        ar_addr_q  <= s_ar_addr;
        ar_id_q    <= s_ar_id;
        ar_len_q   <= s_ar_len;
        ar_size_q  <= s_ar_size;
        ar_burst_q <= s_ar_burst;
      end else if (ar_fwd || ar_take_bad) begin
        ar_full_q <= 1'b0;
      end
      if (aw_take_bad) err_wid_q <= aw_id_q;
      if (ar_take_bad) begin
        err_rid_q  <= ar_id_q;
        err_rlen_q <= ar_len_q;
      end
    end
  end
endmodule

// File: tb/tb_mem_axi_window_bridge.sv
// Self-checking bench for mem_axi_window_bridge: randomized bursts checked against address
// remap and DECERR rules computed directly in the bench.
module tb_mem_axi_window_bridge;
  localparam int         ID_W = 6;
  localparam logic [3:0] WIN  = 4'h8;
  localparam logic [3:0] DDR  = 4'h1;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_w_last, s_b_valid, s_b_ready;
  logic s_ar_valid, s_ar_ready, s_r_valid, s_r_ready, s_r_last;
  logic [31:0] s_aw_addr, s_ar_addr, m_aw_addr, m_ar_addr;
  logic [ID_W-1:0] s_aw_id, s_ar_id, s_b_id, s_r_id, m_aw_id, m_ar_id, m_b_id, m_r_id;
  logic [7:0] s_aw_len, s_ar_len, m_aw_len, m_ar_len, s_w_strb, m_w_strb;
  logic [2:0] s_aw_size, s_ar_size, m_aw_size, m_ar_size, m_aw_prot, m_ar_prot;
  logic [1:0] s_aw_burst, s_ar_burst, m_aw_burst, m_ar_burst, s_b_resp, s_r_resp;
  logic [1:0] m_b_resp, m_r_resp;
  logic [63:0] s_w_data, m_w_data, s_r_data, m_r_data;
  logic [3:0] m_aw_cache, m_ar_cache, m_aw_qos, m_ar_qos;
  logic m_aw_lock, m_ar_lock, m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_w_last;
  logic m_b_valid, m_b_ready, m_ar_valid, m_ar_ready, m_r_valid, m_r_ready, m_r_last;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  mem_axi_window_bridge #(.WIN_TAG(WIN), .DDR_TAG(DDR), .ID_W(ID_W), .MAX_OUT(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr), .s_aw_id(s_aw_id),
    .s_aw_len(s_aw_len), .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
    .s_w_last(s_w_last), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id),
    .s_b_resp(s_b_resp),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr), .s_ar_id(s_ar_id),
    .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id), .s_r_data(s_r_data),
    .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr), .m_aw_id(m_aw_id),
    .m_aw_len(m_aw_len), .m_aw_size(m_aw_size), .m_aw_burst(m_aw_burst),
    .m_aw_cache(m_aw_cache), .m_aw_prot(m_aw_prot), .m_aw_qos(m_aw_qos), .m_aw_lock(m_aw_lock),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
    .m_w_last(m_w_last), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_id(m_b_id),
    .m_b_resp(m_b_resp),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr), .m_ar_id(m_ar_id),
    .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst),
    .m_ar_cache(m_ar_cache), .m_ar_prot(m_ar_prot), .m_ar_qos(m_ar_qos), .m_ar_lock(m_ar_lock),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_id(m_r_id), .m_r_data(m_r_data),
    .m_r_resp(m_r_resp), .m_r_last(m_r_last)
  );

  // Reference rules: the window is the top nibble; forwarded addresses swap it for the DDR tag.
  function automatic logic [31:0] ref_remap(input logic [31:0] a);
    return {DDR, a[27:0]};
  endfunction
  function automatic logic [31:0] rand_good_addr();
    return {WIN, 28'($urandom)};
  endfunction
  function automatic logic [31:0] rand_bad_addr();
    logic [3:0] t;
    t = 4'($urandom_range(0, 15));
    if (t == WIN) t = 4'h4;
    return {t, 28'($urandom)};
  endfunction

  task automatic init_inputs();
    s_aw_valid = 0; s_aw_addr = 0; s_aw_id = 0; s_aw_len = 0; s_aw_size = 3'd3;
    s_aw_burst = 2'b01; s_w_valid = 0; s_w_data = 0; s_w_strb = 0; s_w_last = 0;
    s_b_ready = 1; s_ar_valid = 0; s_ar_addr = 0; s_ar_id = 0; s_ar_len = 0;
    s_ar_size = 3'd3; s_ar_burst = 2'b01; s_r_ready = 1;
    m_aw_ready = 1; m_w_ready = 1; m_b_valid = 0; m_b_id = 0; m_b_resp = 0;
    m_ar_ready = 1; m_r_valid = 0; m_r_id = 0; m_r_data = 0; m_r_resp = 0; m_r_last = 0;
  endtask

  task automatic test_reset();
    logic [9:0] hs;
    init_inputs();
    s_aw_valid = 1; s_aw_addr = 32'h8000_0000; s_ar_valid = 1; s_ar_addr = 32'h8000_0000;
    s_w_valid = 1; m_b_valid = 1; m_r_valid = 1;
    repeat (2) @(negedge clock);
    #1;
    hs = {s_aw_ready, s_ar_ready, s_w_ready, m_b_ready, m_r_ready,
          s_b_valid, s_r_valid, m_aw_valid, m_ar_valid, m_w_valid};
    total++;
    if (hs !== 10'b0) begin
      bad++; $display("FAIL reset_handshakes: got %b want 0000000000", hs);
    end
    total++;
    if ({m_aw_cache, m_aw_prot, m_aw_qos, m_aw_lock} !== 12'b0011_000_0000_0) begin
      bad++; $display("FAIL aw_const: got %h want 0300", {m_aw_cache, m_aw_prot, m_aw_qos, m_aw_lock});
    end
    total++;
    if ({m_ar_cache, m_ar_prot, m_ar_qos, m_ar_lock} !== 12'b0011_000_0000_0) begin
      bad++; $display("FAIL ar_const: got %h want 0300", {m_ar_cache, m_ar_prot, m_ar_qos, m_ar_lock});
    end
    init_inputs();
    @(negedge clock);
    reset_n = 1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_read_fwd();
    for (int it = 0; it < 3; it++) begin
      logic [31:0] a;
      logic [ID_W-1:0] id;
      logic [7:0] len;
      logic [63:0] d;
      a = (it == 0) ? 32'h8000_1000 : rand_good_addr();
      id = ID_W'($urandom);
      len = (it == 0) ? 8'd3 : 8'($urandom_range(0, 5));
      @(negedge clock);
      s_ar_valid = 1; s_ar_addr = a; s_ar_id = id; s_ar_len = len;
      #1;
      total++;
      if (s_ar_ready !== 1'b1) begin bad++; $display("FAIL rf_ar_ready: got %b want 1", s_ar_ready); end
      @(negedge clock);
      s_ar_valid = 0;
      #1;
      total++;
      if ({m_ar_valid, m_ar_addr, m_ar_id, m_ar_len} !== {1'b1, ref_remap(a), id, len}) begin
        bad++;
        $display("FAIL rf_m_ar: got v=%b a=%h id=%h len=%0d want v=1 a=%h id=%h len=%0d",
                 m_ar_valid, m_ar_addr, m_ar_id, m_ar_len, ref_remap(a), id, len);
      end
      for (int b = 0; b <= int'(len); b++) begin
        @(negedge clock);
        d = {$urandom, $urandom};
        m_r_valid = 1; m_r_id = id; m_r_data = d; m_r_resp = 2'b00; m_r_last = (b == int'(len));
        #1;
        total++;
        if ({s_r_valid, s_r_id, s_r_data, s_r_resp, s_r_last, m_r_ready} !==
            {1'b1, id, d, 2'b00, b == int'(len), 1'b1}) begin
          bad++;
          $display("FAIL rf_r_beat%0d: got v=%b id=%h d=%h last=%b mr=%b want v=1 id=%h d=%h last=%b",
                   b, s_r_valid, s_r_id, s_r_data, s_r_last, m_r_ready, id, d, b == int'(len));
        end
        if (b == 0) begin
          total++;
          if (m_ar_valid !== 1'b0) begin bad++; $display("FAIL rf_ar_once: got %b want 0", m_ar_valid); end
        end
      end
      @(negedge clock);
      m_r_valid = 0; m_r_last = 0;
      #1;
      total++;
      if (dut.rd_out_q !== 4'd0) begin bad++; $display("FAIL rf_rd_out: got %0d want 0", dut.rd_out_q); end
    end
  endtask

  task automatic test_write_fwd();
    for (int it = 0; it < 2; it++) begin
      logic [31:0] a;
      logic [ID_W-1:0] id;
      logic [7:0] len;
      logic [63:0] d;
      logic [7:0] st;
      a = (it == 0) ? 32'h8000_0040 : rand_good_addr();
      id = ID_W'($urandom);
      len = (it == 0) ? 8'd1 : 8'($urandom_range(0, 3));
      @(negedge clock);
      s_aw_valid = 1; s_aw_addr = a; s_aw_id = id; s_aw_len = len;
      #1;
      total++;
      if (s_aw_ready !== 1'b1) begin bad++; $display("FAIL wf_aw_ready: got %b want 1", s_aw_ready); end
      @(negedge clock);
      s_aw_valid = 0;
      for (int b = 0; b <= int'(len); b++) begin
        if (b != 0) @(negedge clock);
        d = {$urandom, $urandom};
        st = 8'($urandom);
        s_w_valid = 1; s_w_data = d; s_w_strb = st; s_w_last = (b == int'(len));
        #1;
        if (b == 0) begin
          total++;
          if ({m_aw_valid, m_aw_addr, m_aw_id, m_aw_len} !== {1'b1, ref_remap(a), id, len}) begin
            bad++;
            $display("FAIL wf_m_aw: got v=%b a=%h id=%h want v=1 a=%h id=%h",
                     m_aw_valid, m_aw_addr, m_aw_id, ref_remap(a), id);
          end
        end
        total++;
        if ({m_w_valid, s_w_ready, m_w_data, m_w_strb, m_w_last} !==
            {1'b1, 1'b1, d, st, b == int'(len)}) begin
          bad++;
          $display("FAIL wf_w_beat%0d: got v=%b r=%b d=%h s=%h l=%b want v=1 r=1 d=%h s=%h",
                   b, m_w_valid, s_w_ready, m_w_data, m_w_strb, m_w_last, d, st);
        end
      end
      @(negedge clock);
      s_w_valid = 0; s_w_last = 0;
      m_b_valid = 1; m_b_id = id; m_b_resp = 2'b00; s_b_ready = 1;
      #1;
      total++;
      if ({s_b_valid, s_b_id, s_b_resp, m_b_ready} !== {1'b1, id, 2'b00, 1'b1}) begin
        bad++;
        $display("FAIL wf_b: got v=%b id=%h resp=%b r=%b want v=1 id=%h resp=00 r=1",
                 s_b_valid, s_b_id, s_b_resp, m_b_ready, id);
      end
      @(negedge clock);
      m_b_valid = 0;
      #1;
      total++;
      if ({dut.wr_out_q, dut.w_pend_q} !== 8'h00) begin
        bad++; $display("FAIL wf_counters: got %h want 00", {dut.wr_out_q, dut.w_pend_q});
      end
    end
  endtask

  task automatic test_read_err();
    for (int it = 0; it < 3; it++) begin
      logic [31:0] a;
      logic [ID_W-1:0] id;
      logic [7:0] len;
      int beat;
      bit done;
      a = (it == 0) ? 32'h4000_0000 : rand_bad_addr();
      id = (it == 0) ? ID_W'(5) : ID_W'($urandom);
      len = (it == 0) ? 8'd2 : 8'($urandom_range(0, 4));
      @(negedge clock);
      s_ar_valid = 1; s_ar_addr = a; s_ar_id = id; s_ar_len = len;
      #1;
      total++;
      if (s_ar_ready !== 1'b1) begin bad++; $display("FAIL re_ar_ready: got %b want 1", s_ar_ready); end
      beat = 0;
      done = 0;
      for (int n = 0; n < 60 && !done; n++) begin
        @(negedge clock);
        s_ar_valid = 0;
        s_r_ready = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        #1;
        total++;
        if (m_ar_valid !== 1'b0) begin bad++; $display("FAIL re_no_fwd: got %b want 0", m_ar_valid); end
        if (s_r_valid === 1'b1) begin
          total++;
          if ({s_r_id, s_r_data, s_r_resp, s_r_last, m_r_ready} !==
              {id, 64'd0, 2'b11, beat == int'(len), 1'b0}) begin
            bad++;
            $display("FAIL re_beat%0d: got id=%h d=%h resp=%b last=%b mr=%b want id=%h d=0 resp=11 last=%b mr=0",
                     beat, s_r_id, s_r_data, s_r_resp, s_r_last, m_r_ready, id, beat == int'(len));
          end
          if (s_r_ready) begin
            if (beat == int'(len)) done = 1;
            beat++;
          end
        end
      end
      total++;
      if (!done) begin bad++; $display("FAIL re_timeout: got %0d beats want %0d", beat, len + 1); end
      @(negedge clock);
      s_r_ready = 1;
      #1;
      total++;
      if (s_r_valid !== 1'b0) begin bad++; $display("FAIL re_idle: got %b want 0", s_r_valid); end
    end
  endtask

  task automatic test_write_err();
    logic [ID_W-1:0] gid, bid;
    logic [31:0] ba;
    int k;
    gid = ID_W'($urandom);
    bid = ID_W'($urandom);
    ba = rand_bad_addr();
    @(negedge clock);
    s_aw_valid = 1; s_aw_addr = rand_good_addr(); s_aw_id = gid; s_aw_len = 0;
    #1;
    total++;
    if (s_aw_ready !== 1'b1) begin bad++; $display("FAIL we_good_ready: got %b want 1", s_aw_ready); end
    @(negedge clock);
    s_aw_valid = 0; s_w_valid = 1; s_w_data = {$urandom, $urandom}; s_w_last = 1;
    #1;
    total++;
    if (m_w_valid !== 1'b1) begin bad++; $display("FAIL we_good_w: got %b want 1", m_w_valid); end
    @(negedge clock);
    s_w_valid = 0; s_w_last = 0;
    s_aw_valid = 1; s_aw_addr = ba; s_aw_id = bid; s_aw_len = 3;
    #1;
    total++;
    if ({dut.wr_out_q, dut.w_pend_q} !== 8'h10) begin
      bad++; $display("FAIL we_counters: got %h want 10", {dut.wr_out_q, dut.w_pend_q});
    end
    total++;
    if (s_aw_ready !== 1'b1) begin bad++; $display("FAIL we_bad_ready: got %b want 1", s_aw_ready); end
    for (int n = 0; n < 5; n++) begin
      @(negedge clock);
      s_aw_valid = 0; s_w_valid = 1; s_w_data = {$urandom, $urandom}; s_w_last = 0;
      #1;
      total++;
      if ({s_w_ready, s_b_valid, s_aw_ready} !== 3'b000) begin
        bad++; $display("FAIL we_held: got %b want 000", {s_w_ready, s_b_valid, s_aw_ready});
      end
    end
    @(negedge clock);
    m_b_valid = 1; m_b_id = gid; m_b_resp = 2'b00; s_b_ready = 1;
    #1;
    total++;
    if ({s_b_valid, s_b_id, s_b_resp} !== {1'b1, gid, 2'b00}) begin
      bad++; $display("FAIL we_good_b: got v=%b id=%h resp=%b want v=1 id=%h resp=00",
                      s_b_valid, s_b_id, s_b_resp, gid);
    end
    k = 0;
    for (int n = 0; n < 20 && k < 4; n++) begin
      @(negedge clock);
      m_b_valid = 0;
      s_w_last = (k == 3);
      #1;
      total++;
      if (m_w_valid !== 1'b0) begin bad++; $display("FAIL we_sink_leak: got %b want 0", m_w_valid); end
      if (s_w_ready === 1'b1) begin
        k++;
        s_w_data = {$urandom, $urandom};
      end
    end
    total++;
    if (k != 4) begin bad++; $display("FAIL we_sink_timeout: got %0d beats want 4", k); end
    @(negedge clock);
    s_w_valid = 0; s_w_last = 0; s_b_ready = 0;
    #1;
    total++;
    if ({s_b_valid, s_b_id, s_b_resp, m_b_ready} !== {1'b1, bid, 2'b11, 1'b0}) begin
      bad++; $display("FAIL we_err_b: got v=%b id=%h resp=%b mr=%b want v=1 id=%h resp=11 mr=0",
                      s_b_valid, s_b_id, s_b_resp, m_b_ready, bid);
    end
    @(negedge clock);
    s_b_ready = 1;
    #1;
    total++;
    if (s_b_valid !== 1'b1) begin bad++; $display("FAIL we_b_hold: got %b want 1", s_b_valid); end
    @(negedge clock);
    #1;
    total++;
    if (s_b_valid !== 1'b0) begin bad++; $display("FAIL we_b_done: got %b want 0", s_b_valid); end
  endtask

  task automatic test_ar_stall();
    logic [31:0] a9;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      s_ar_valid = 1; s_ar_addr = rand_good_addr(); s_ar_id = ID_W'(i); s_ar_len = 0;
      #1;
      total++;
      if (s_ar_ready !== 1'b1) begin bad++; $display("FAIL st_ar%0d_ready: got %b want 1", i, s_ar_ready); end
      @(negedge clock);
      s_ar_valid = 0;
    end
    a9 = rand_good_addr();
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      s_ar_valid = 1; s_ar_addr = a9; s_ar_id = ID_W'(9);
      #1;
      total++;
      if (s_ar_ready !== 1'b0) begin bad++; $display("FAIL st_ar9_stall: got %b want 0", s_ar_ready); end
    end
    @(negedge clock);
    m_r_valid = 1; m_r_id = 0; m_r_last = 1; s_r_ready = 1;
    #1;
    total++;
    if (s_ar_ready !== 1'b0) begin bad++; $display("FAIL st_ar9_pre: got %b want 0", s_ar_ready); end
    @(negedge clock);
    m_r_valid = 0;
    #1;
    total++;
    if (s_ar_ready !== 1'b1) begin bad++; $display("FAIL st_ar9_accept: got %b want 1", s_ar_ready); end
    @(negedge clock);
    s_ar_valid = 0;
    #1;
    total++;
    if ({m_ar_valid, m_ar_addr} !== {1'b1, ref_remap(a9)}) begin
      bad++; $display("FAIL st_ar9_fwd: got v=%b a=%h want v=1 a=%h", m_ar_valid, m_ar_addr, ref_remap(a9));
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      m_r_valid = 1; m_r_last = 1;
    end
    @(negedge clock);
    m_r_valid = 0; m_r_last = 0;
    #1;
    total++;
    if (dut.rd_out_q !== 4'd0) begin bad++; $display("FAIL st_drain: got %0d want 0", dut.rd_out_q); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a;
    bit seen;
    @(negedge clock);
    s_ar_valid = 1; s_ar_addr = rand_bad_addr(); s_ar_id = ID_W'($urandom); s_ar_len = 3;
    s_r_ready = 1;
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clock);
      s_ar_valid = 0;
      #1;
      if (s_r_valid === 1'b1) seen = 1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL rm_no_rerr: got 0 want 1"); end
    @(negedge clock);
    #1;
    total++;
    if ({s_r_valid, s_r_last} !== 2'b10) begin
      bad++; $display("FAIL rm_beat2: got %b want 10", {s_r_valid, s_r_last});
    end
    reset_n = 0;
    #1;
    total++;
    if ({s_r_valid, s_ar_ready, s_aw_ready} !== 3'b000) begin
      bad++; $display("FAIL rm_async: got %b want 000", {s_r_valid, s_ar_ready, s_aw_ready});
    end
    @(negedge clock);
    reset_n = 1;
    @(negedge clock);
    a = rand_good_addr();
    s_ar_valid = 1; s_ar_addr = a; s_ar_len = 0;
    #1;
    total++;
    if ({s_r_valid, s_ar_ready} !== 2'b01) begin
      bad++; $display("FAIL rm_after: got %b want 01", {s_r_valid, s_ar_ready});
    end
    @(negedge clock);
    s_ar_valid = 0;
    #1;
    total++;
    if ({m_ar_valid, m_ar_addr} !== {1'b1, ref_remap(a)}) begin
      bad++; $display("FAIL rm_fwd: got v=%b a=%h want v=1 a=%h", m_ar_valid, m_ar_addr, ref_remap(a));
    end
  endtask

  initial begin
    test_reset();
    test_read_fwd();
    test_write_fwd();
    test_read_err();
    test_write_err();
    test_ar_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
